scene_sequencer: RTL

Top-level scene controller for the VGA game. It sequences the menu, handoff, play and game-over scenes, and drives the start/ready handshake towards the main game engine. It arbitrates the menu and main-game pixel streams onto one RGB output and applies frame-timed fade-out/fade-in brightness scaling. It sits between the menu/main scene modules and the display output stage.

---
 rtl/scene_sequencer_if.sv | 37 +++
 rtl/scene_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/scene_sequencer_if.sv
// Signal bundle between the scene sequencer and its surroundings: scene
// handshakes and pixel streams in, scaled pixel and status out.
interface scene_sequencer_if;
  logic        i_frame;
  logic        i_menu_req;
  logic        i_key_continue;
  logic        i_main_ready;
  logic        i_main_over;
  logic        i_menu_drawing;
  logic [23:0] i_menu_rgb;
  logic        i_main_drawing;
  logic [23:0] i_main_rgb;
  logic        o_main_start;
  logic        o_menu_en;
  logic        o_main_en;
  logic        o_timeout;
  logic [2:0]  o_state;
  logic [4:0]  o_level;
  logic        o_drawing;
  logic [7:0]  o_red;
  logic [7:0]  o_blue;
  logic [7:0]  o_green;

  modport master (
    output i_frame, i_menu_req, i_key_continue, i_main_ready, i_main_over,
           i_menu_drawing, i_menu_rgb, i_main_drawing, i_main_rgb,
    input  o_main_start, o_menu_en, o_main_en, o_timeout, o_state, o_level,
           o_drawing, o_red, o_blue, o_green
  );

  modport slave (
    input  i_frame, i_menu_req, i_key_continue, i_main_ready, i_main_over,
           i_menu_drawing, i_menu_rgb, i_main_drawing, i_main_rgb,
    output o_main_start, o_menu_en, o_main_en, o_timeout, o_state, o_level,
           o_drawing, o_red, o_blue, o_green
  );
endinterface

// File: rtl/scene_sequencer.sv
// Scene controller: sequences menu -> fade -> handoff -> fade -> play -> over,
// selects the active scene's pixel stream and scales it by the fade level.
module scene_sequencer #(
  parameter int          FADE_DIV        = 2,
  parameter int          HANDOFF_TIMEOUT = 60,
  parameter int          OVER_LEVEL      = 8,
  parameter logic [23:0] BG_COLOR        = 24'h00FFFF
) (
  input logic              i_clk_pix,
  input logic              i_rst,
  scene_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_MENU     = 3'd0,
    S_FADE_OUT = 3'd1,
    S_HANDOFF  = 3'd2,
    S_FADE_IN  = 3'd3,
    S_PLAY     = 3'd4,
    S_OVER     = 3'd5
  } state_t;

  localparam logic [7:0]  FRM_LAST = 8'(FADE_DIV - 1);
  localparam logic [15:0] TO_LAST  = 16'(HANDOFF_TIMEOUT - 1);
  localparam logic [4:0]  LVL_MAX  = 5'd16;
  localparam logic [4:0]  LVL_OVER = 5'(OVER_LEVEL);

  // Brightness scaling: 255*16 fits in 12 bits, so a 13-bit product is exact.
  function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [4:0] lvl);
    logic [12:0] prod;
    prod = {5'd0, ch} * {8'd0, lvl};
    return 8'(prod >> 4);
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  level_q, level_d;
  logic        scene_main_q, scene_main_d;
  logic        tgt_play_q, tgt_play_d;
  logic        main_start_q, main_start_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  frm_q, frm_d;
  logic [15:0] to_q, to_d;
  logic        req_q, key_q, armed_q;
  logic        drawing_q, drawing_d;
  logic [7:0]  red_q, red_d, blue_q, blue_d, green_q, green_d;

  logic        menu_rise, key_rise, tick;
  logic        sel_drawing;
  logic [23:0] sel_rgb, src_rgb;

  // armed_q masks the first cycle after reset so a request held high through
  // reset release is not mistaken for a fresh rising edge.
  assign menu_rise = armed_q & bus.i_menu_req & ~req_q;
  assign key_rise  = armed_q & bus.i_key_continue & ~key_q;

  // Next-state, fade level, counters and scene selection.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    scene_main_d = scene_main_q;
    tgt_play_d   = tgt_play_q;
    timeout_d    = timeout_q;
    frm_d        = frm_q;
    to_d         = to_q;
    tick         = 1'b0;

    if ((state_q == S_FADE_OUT || state_q == S_FADE_IN) && bus.i_frame) begin
      if (frm_q == FRM_LAST) begin
        tick  = 1'b1;
        frm_d = 8'd0;
      end else begin
        frm_d = frm_q + 8'd1;
      end
    end

    unique case (state_q)
      S_MENU: begin
        if (menu_rise) begin
          state_d    = S_FADE_OUT;
          tgt_play_d = 1'b1;
        end
      end
      S_FADE_OUT: begin
        if (tick) begin
          if (level_q == 5'd0) begin
            if (tgt_play_q) begin
              scene_main_d = 1'b1;
              state_d      = S_HANDOFF;
            end else begin
              scene_main_d = 1'b0;
              state_d      = S_FADE_IN;
            end
          end else begin
            level_d = level_q - 5'd1;
          end
        end
      end
      S_HANDOFF: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (bus.i_main_ready) begin
          state_d    = S_FADE_IN;
          tgt_play_d = 1'b1;
        end else if (bus.i_frame) begin
          if (to_q == TO_LAST) begin
            timeout_d    = 1'b1;
            scene_main_d = 1'b0;
            tgt_play_d   = 1'b0;
            state_d      = S_FADE_IN;
          end else begin
            to_d = to_q + 16'd1;
          end
        end
      end
      S_FADE_IN: begin
        if (tick) begin
          if (level_q == LVL_MAX) begin
            state_d = tgt_play_q ? S_PLAY : S_MENU;
          end else begin
            level_d = level_q + 5'd1;
          end
        end
      end
      S_PLAY: begin
        if (bus.i_main_over) begin
          state_d = S_OVER;
          level_d = LVL_OVER;
        end
      end
      S_OVER: begin
        if (key_rise) begin
          state_d    = S_FADE_OUT;
          tgt_play_d = 1'b0;
        end
      end
      default: state_d = S_MENU;
    endcase

    if (state_d != state_q) begin
      frm_d = 8'd0;
      to_d  = 16'd0;
    end
    main_start_d = (state_d == S_HANDOFF);
  end

  // Pixel selection and scaling, sampled with the current level and scene.
  always_comb begin
    sel_drawing = scene_main_q ? bus.i_main_drawing : bus.i_menu_drawing;
    sel_rgb     = scene_main_q ? bus.i_main_rgb : bus.i_menu_rgb;
    src_rgb     = sel_drawing ? sel_rgb : BG_COLOR;
    drawing_d   = sel_drawing;
    red_d       = scale_ch(src_rgb[23:16], level_q);
    blue_d      = scale_ch(src_rgb[15:8], level_q);
    green_d     = scale_ch(src_rgb[7:0], level_q);
  end

  // Control registers and edge detectors.
  always_ff @(posedge i_clk_pix or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_MENU;
      level_q      <= LVL_MAX;
      scene_main_q <= 1'b0;
      tgt_play_q   <= 1'b1;
      main_start_q <= 1'b0;
      timeout_q    <= 1'b0;
      frm_q        <= 8'd0;
      to_q         <= 16'd0;
      req_q        <= 1'b0;
      key_q        <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      scene_main_q <= scene_main_d;
      tgt_play_q   <= tgt_play_d;
      main_start_q <= main_start_d;
      timeout_q    <= timeout_d;
      frm_q        <= frm_d;
      to_q         <= to_d;
      req_q        <= bus.i_menu_req;
      key_q        <= bus.i_key_continue;
      armed_q      <= 1'b1;
    end
  end

  // Registered pixel output, one cycle behind the input stream.
  always_ff @(posedge i_clk_pix or posedge i_rst) begin
    if (i_rst) begin
      drawing_q <= 1'b0;
      red_q     <= 8'd0;
      blue_q    <= 8'd0;
      green_q   <= 8'd0;
    end else begin
      drawing_q <= drawing_d;
      red_q     <= red_d;
      blue_q    <= blue_d;
      green_q   <= green_d;
    end
  end

  assign bus.o_main_start = main_start_q;
  assign bus.o_menu_en    = ~scene_main_q;
  assign bus.o_main_en    = scene_main_q;
  assign bus.o_timeout    = timeout_q;
  assign bus.o_state      = state_q;
  assign bus.o_level      = level_q;
  assign bus.o_drawing    = drawing_q;
  assign bus.o_red        = red_q;
  assign bus.o_blue       = blue_q;
  assign bus.o_green      = green_q;

endmodule
